// File: rtl/matmul_seq_ctrl_if.sv
// Control/status bundle between the multiply controller and its host.
// The host side drives start/stall; the controller side returns RAM addresses and MAC strobes.
interface matmul_seq_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             stall;
  logic [WIDTH-1:0] counter_A;
  logic [WIDTH-1:0] counter_B;
  logic             mac_en;
  logic             mac_clr;
  logic             mac_last;
  logic [WIDTH-1:0] out_row;
  logic [WIDTH-1:0] out_col;
  logic             busy;
  logic             done;

  modport master (
    output start, stall,
    input  counter_A, counter_B, mac_en, mac_clr, mac_last, out_row, out_col, busy, done
  );

  modport slave (
    input  start, stall,
    output counter_A, counter_B, mac_en, mac_clr, mac_last, out_row, out_col, busy, done
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Address sequencer + MAC strobe generator for a single-MAC matmul; strobes lag the issued address by
// one cycle to line up with registered-read RAM data. stall freezes address issue without double-counting.
module matmul_seq_ctrl #(
  parameter int WIDTH           = 16,
  parameter int CHUNK_SIZE      = 4,
  parameter int INNER_DIMENSION = 8,
  parameter int ROWS_A          = 6,
  parameter int COLS_B          = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  matmul_seq_ctrl_if.slave  bus
);
  localparam int NC = INNER_DIMENSION / CHUNK_SIZE;
  localparam logic [WIDTH-1:0] NC_W   = WIDTH'(NC);
  localparam logic [WIDTH-1:0] K_LAST = WIDTH'(NC - 1);
  localparam logic [WIDTH-1:0] J_LAST = WIDTH'(COLS_B - 1);
  localparam logic [WIDTH-1:0] I_LAST = WIDTH'(ROWS_A - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] i_q, j_q, k_q;
  logic [WIDTH-1:0] i_nxt, j_nxt, k_nxt;
  logic             issue, k_wrap, j_wrap, i_wrap, last_issue;

  always_comb begin
    issue      = (state == RUN) && !bus.stall;
    k_wrap     = (k_q == K_LAST);
    j_wrap     = (j_q == J_LAST);
    i_wrap     = (i_q == I_LAST);
    last_issue = issue && k_wrap && j_wrap && i_wrap;

    i_nxt = i_q;
    j_nxt = j_q;
    k_nxt = k_q;
    // Outside RUN the indices are parked at zero so the next run starts at (0,0).
    if (state != RUN) begin
      i_nxt = '0;
      j_nxt = '0;
      k_nxt = '0;
    end else if (issue) begin
      k_nxt = k_wrap ? '0 : k_q + ONE;
      if (k_wrap) begin
        j_nxt = j_wrap ? '0 : j_q + ONE;
        if (j_wrap) begin
          i_nxt = i_wrap ? '0 : i_q + ONE;
        end
      end
    end

    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      bus.counter_A <= '0;
      bus.counter_B <= '0;
      bus.mac_en    <= 1'b0;
      bus.mac_clr   <= 1'b0;
      bus.mac_last  <= 1'b0;
      bus.out_row   <= '0;
      bus.out_col   <= '0;
    end else begin
      state         <= state_nxt;
      i_q           <= i_nxt;
      j_q           <= j_nxt;
      k_q           <= k_nxt;
      bus.counter_A <= i_nxt * NC_W + k_nxt;
      bus.counter_B <= j_nxt * NC_W + k_nxt;
      // One stage behind issue, matching the RAM read latency.
      bus.mac_en    <= issue;
      bus.mac_clr   <= issue && (k_q == '0);
      bus.mac_last  <= issue && k_wrap;
      if (issue) begin
        bus.out_row <= i_q;
        bus.out_col <= j_q;
      end
    end
  end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench: stimulus pushes expected MAC beats and done cycles, negedge monitors pop and compare.
module tb_matmul_seq_ctrl;
  logic clk;
  logic rst_n;
  int   cyc;
  int   t0;
  int   checks;
  int   failures;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] row;
    logic [15:0] col;
    logic        clr;
    logic        last;
  } exp_t;

  exp_t        exp_q0[$];
  exp_t        exp_q1[$];
  int          done_q0[$];
  int          done_q1[$];
  logic [15:0] prev_a[2];
  logic [15:0] prev_b[2];

  matmul_seq_ctrl_if #(.WIDTH(16)) bus0 ();
  matmul_seq_ctrl_if #(.WIDTH(16)) bus1 ();

  matmul_seq_ctrl #(
    .WIDTH(16), .CHUNK_SIZE(4), .INNER_DIMENSION(8), .ROWS_A(6), .COLS_B(6)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );

  matmul_seq_ctrl #(
    .WIDTH(16), .CHUNK_SIZE(8), .INNER_DIMENSION(8), .ROWS_A(2), .COLS_B(3)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_run(input int d, input int ra, input int cb, input int nc);
    exp_t e;
    for (int i = 0; i < ra; i++)
      for (int j = 0; j < cb; j++)
        for (int k = 0; k < nc; k++) begin
          e.a    = 16'(i * nc + k);
          e.b    = 16'(j * nc + k);
          e.row  = 16'(i);
          e.col  = 16'(j);
          e.clr  = (k == 0);
          e.last = (k == nc - 1);
          if (d == 0) exp_q0.push_back(e);
          else        exp_q1.push_back(e);
        end
  endtask

  task automatic mon_step(input int d, input logic en, input logic clr, input logic last,
                          input logic bsy, input logic dn, input logic [15:0] row,
                          input logic [15:0] col, input logic [15:0] ca, input logic [15:0] cb);
    exp_t e;
    int   sz;
    int   ec;
    if (rst_n) begin
      if (en) begin
        sz = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_mac_en dut%0d actual=1 required=0 (t=%0t)", d, $time);
        end else begin
          if (d == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check($sformatf("mac_beat_dut%0d{A,B,row,col,clr,last}", d),
                {prev_a[d], prev_b[d], row, col, clr, last},
                {e.a, e.b, e.row, e.col, e.clr, e.last});
        end
      end else begin
        check($sformatf("idle_flags_dut%0d{clr,last}", d), {clr, last}, 2'b00);
      end
      if (dn) begin
        sz = (d == 0) ? done_q0.size() : done_q1.size();
        if (sz == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done dut%0d actual=1 required=0 (t=%0t)", d, $time);
        end else begin
          if (d == 0) ec = done_q0.pop_front();
          else        ec = done_q1.pop_front();
          check($sformatf("done_cycle_dut%0d", d), cyc - t0 + 1, ec);
          check($sformatf("busy_at_done_dut%0d", d), bsy, 1'b1);
        end
      end
    end
    prev_a[d] = ca;
    prev_b[d] = cb;
  endtask

  always @(negedge clk)
    mon_step(0, bus0.mac_en, bus0.mac_clr, bus0.mac_last, bus0.busy, bus0.done,
             bus0.out_row, bus0.out_col, bus0.counter_A, bus0.counter_B);

  always @(negedge clk)
    mon_step(1, bus1.mac_en, bus1.mac_clr, bus1.mac_last, bus1.busy, bus1.done,
             bus1.out_row, bus1.out_col, bus1.counter_A, bus1.counter_B);

  task automatic check_zero(input string nm);
    check(nm, {bus0.counter_A, bus0.counter_B, bus0.out_row, bus0.out_col, bus0.mac_en,
               bus0.mac_clr, bus0.mac_last, bus0.busy, bus0.done}, 128'd0);
  endtask

  task automatic run(input bit do_stall, input bit do_restart, input int abort_at, input bit dual);
    int c;
    bit drained;
    @(posedge clk);
    #1;
    push_run(0, 6, 6, 2);
    done_q0.push_back(do_stall ? 77 : 74);
    if (dual) begin
      push_run(1, 2, 3, 1);
      done_q1.push_back(8);
    end
    bus0.start = 1'b1;
    bus1.start = dual;
    @(posedge clk);
    #1;
    t0 = cyc;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    c = 1;
    drained = 1'b0;
    while (!drained && c < 300) begin
      if (do_stall && c == 5)    bus0.stall = 1'b1;
      if (do_stall && c == 8)    bus0.stall = 1'b0;
      if (do_restart && c == 30) bus0.start = 1'b1;
      if (do_restart && c == 31) bus0.start = 1'b0;
      if (abort_at != 0 && c == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_zero("abort_outputs_zero");
        exp_q0.delete();
        done_q0.delete();
        exp_q1.delete();
        done_q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      c++;
      drained = (exp_q0.size() == 0) && (done_q0.size() == 0) &&
                (exp_q1.size() == 0) && (done_q1.size() == 0);
    end
    if (!drained) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=%0d pending required=0 pending", exp_q0.size() + done_q0.size());
      exp_q0.delete();
      done_q0.delete();
      exp_q1.delete();
      done_q1.delete();
    end else begin
      check("busy_done_after_run", {bus0.busy, bus0.done}, 2'b00);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    t0         = 0;
    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus0.stall = 1'b0;
    bus1.start = 1'b0;
    bus1.stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state_dut0");
    check("reset_state_dut1", {bus1.counter_A, bus1.counter_B, bus1.out_row, bus1.out_col,
                               bus1.mac_en, bus1.mac_clr, bus1.mac_last, bus1.busy, bus1.done},
          128'd0);
    rst_n = 1'b1;

    run(1'b0, 1'b0, 0, 1'b1);   // plain run on both configurations
    run(1'b1, 1'b0, 0, 1'b0);   // stall during cycles 5..7
    run(1'b0, 1'b1, 0, 1'b0);   // start re-pulsed mid-run
    run(1'b0, 1'b0, 40, 1'b0);  // reset mid-run
    run(1'b0, 1'b0, 0, 1'b0);   // clean run after abort

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
